// File: rtl/im_loader_pkg.sv
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared state encodings and IM depth helper for im_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // IM depth in words for a given word-address width.
    function automatic logic [31:0] im_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/im_loader_pack.sv
// ============================================================================
// Module      : im_loader_pack
// Description : Little-endian byte-to-word assembler with a word_ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  r_idx;
    logic [23:0] r_sr;

    // Bytes enter at the top and shift down, so byte 0 lands in [7:0].
    assign word       = {byte_in, r_sr};
    assign word_ready = byte_en && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_idx <= 2'd0;
            r_sr  <= 24'd0;
        end else if (byte_en) begin
            r_idx <= r_idx + 2'd1;
            r_sr  <= word[31:8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// Module      : im_loader
// Description : Boot-time IM writer fed by a byte stream; holds the CPU in
//               reset until a clean load. Optional checksum: IM_LOADER_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [31:0] C_IM_DEPTH = im_depth(ADDR_W);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_word_cnt;
    logic [LEN_W-1:0] w_cnt_next;
    logic [LEN_W-1:0] w_len_hdr;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_data_byte;
    logic             w_last_word;
    logic [31:0]      w_word;
    logic             w_word_ready;
`ifdef IM_LOADER_CKSUM_EN
    logic [7:0]       r_xor;
`endif

    assign w_accept    = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_len_hdr   = {in_data, r_len[7:0]};
    assign w_cnt_next  = r_word_cnt + LEN_W'(1);
    assign w_last_word = (w_cnt_next == r_len);

    im_loader_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_start_ok),
        .byte_en    (w_data_byte),
        .byte_in    (in_data),
        .word       (w_word),
        .word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        cpu_hold    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_LEN0;
            end
            ST_LEN0: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) w_state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) begin
                    if (w_len_hdr == '0)
                        w_state_nxt = ST_DONE;
                    else if ({16'd0, w_len_hdr} > C_IM_DEPTH)
                        w_state_nxt = ST_ERR;
                    else
                        w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_ready && w_last_word) begin
`ifdef IM_LOADER_CKSUM_EN
                    w_state_nxt = ST_CKSUM;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef IM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_accept) w_state_nxt = (in_data == r_xor) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (w_start_ok) w_state_nxt = ST_LEN0;
            end
            ST_ERR: begin
                err = 1'b1;
                if (w_start_ok) w_state_nxt = ST_LEN0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            im_we   <= 1'b0;
            if (w_start_ok) r_word_cnt <= '0;
            if (w_accept && (r_state == ST_LEN0)) r_len[7:0] <= in_data;
            if (w_accept && (r_state == ST_LEN1)) r_len <= w_len_hdr;
            // Write strobe is registered: the IM sees the word one cycle after byte 3.
            if (w_word_ready) begin
                im_we      <= 1'b1;
                im_wdata   <= w_word;
                im_waddr   <= r_word_cnt[ADDR_W-1:0];
                r_word_cnt <= w_cnt_next;
            end
        end
    end

`ifdef IM_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst || w_start_ok)
            r_xor <= 8'd0;
        else if (w_data_byte)
            r_xor <= r_xor ^ in_data;
    end
`endif

endmodule

`default_nettype wire
